// File: rtl/gray_code_counter.sv
// gray_code_counter: up/down binary counter with registered binary and Gray
// outputs, parallel load in binary or Gray format, terminal-count, wrap and
// change flags.
// Optional build macro GRAY_CNT_SAT_EN: when defined, the counter saturates
// at its terminal value instead of wrapping (o_wrap is then always 0).
module gray_code_counter #(
  parameter int unsigned BW_DATA = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_load_gray,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_en,
  input  logic               i_up,
  output logic [BW_DATA-1:0] o_bin,
  output logic [BW_DATA-1:0] o_gray,
  output logic               o_tc,
  output logic               o_wrap,
  output logic               o_chg
);

  localparam int unsigned W = BW_DATA;

  logic [W-1:0] bin_q;
  logic [W-1:0] gray_q;
  logic         wrap_q;
  logic         chg_q;

  logic [W-1:0] load_bin;
  logic [W-1:0] bin_next;
  logic         wrap_next;
  logic         chg_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    load_bin = '0;
    for (int k = 0; k < int'(W); k++) begin
      load_bin[k] = ^(i_data >> k);
    end
  end

  // Terminal count depends only on the current count and the direction
  assign o_tc = i_up ? (bin_q == {W{1'b1}}) : (bin_q == '0);

  // Next count: clear beats load beats count-enable
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (i_clr) begin
      bin_next = '0;
    end else if (i_load) begin
      bin_next = i_load_gray ? load_bin : i_data;
    end else if (i_en) begin
`ifdef GRAY_CNT_SAT_EN
      if (!o_tc) begin
        bin_next = i_up ? (bin_q + W'(1)) : (bin_q - W'(1));
      end
`else
      bin_next  = i_up ? (bin_q + W'(1)) : (bin_q - W'(1));
      wrap_next = o_tc;
`endif
    end
    chg_next = (bin_next != bin_q);
  end

  // Count register, Gray image of the next count and the two pulse flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= bin_next ^ (bin_next >> 1);
      wrap_q <= wrap_next;
      chg_q  <= chg_next;
    end
  end

  assign o_bin  = bin_q;
  assign o_gray = gray_q;
  assign o_wrap = wrap_q;
  assign o_chg  = chg_q;

endmodule
